// File: rtl/barret_3881_sched.sv
// Round-robin share of one combinational mod-3881 reducer; operand-to-result latency 2 cycles, 1 result/cycle.
// A stalled result sink fills both stages, then all req_ready drop. Define BARRET_SCHED_RANGE_CHECK_EN for the sticky err check.
module barret_3881_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DIN_W   = 23,
  parameter int DOUT_W  = 12,
  parameter int MODULUS = 3881
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*DIN_W-1:0] req_data,
  output logic [DIN_W-1:0]         red_din,
  input  logic [DOUT_W-1:0]        red_dout,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DOUT_W-1:0]        res_data,
  output logic [ID_W-1:0]          res_id,
  output logic                     busy,
  output logic                     err
);

  logic              op_vld_q, op_vld_d;
  logic [DIN_W-1:0]  op_dat_q, op_dat_d;
  logic [ID_W-1:0]   op_id_q, op_id_d;
  logic              res_vld_q, res_vld_d;
  logic [DOUT_W-1:0] res_dat_q, res_dat_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic                   s2_load, s1_accept, hs;
  logic [2*NUM_REQ-1:0]   dbl_req, dbl_gnt;
  logic [NUM_REQ-1:0]     rot_req, rot_gnt, grant;
  logic [ID_W-1:0]        gnt_idx, ptr_nxt;
  logic [DIN_W-1:0]       gnt_dat;

  assign s2_load   = op_vld_q && (!res_vld_q || res_ready);
  assign s1_accept = !op_vld_q || s2_load;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign dbl_req = {req_valid, req_valid} >> ptr_q;
  assign rot_req = dbl_req[NUM_REQ-1:0];
  assign rot_gnt = rot_req & (~rot_req + NUM_REQ'(1));
  assign dbl_gnt = {{NUM_REQ{1'b0}}, rot_gnt} << ptr_q;
  assign grant   = dbl_gnt[NUM_REQ-1:0] | dbl_gnt[2*NUM_REQ-1:NUM_REQ];

  always_comb begin
    gnt_idx = '0;
    gnt_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx = ID_W'(i);
        gnt_dat = req_data[i*DIN_W +: DIN_W];
      end
    end
  end

  assign req_ready = (rst_n && s1_accept) ? grant : '0;
  assign hs        = |(req_valid & req_ready);
  assign ptr_nxt   = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);

  always_comb begin
    op_vld_d  = op_vld_q;
    op_dat_d  = op_dat_q;
    op_id_d   = op_id_q;
    res_vld_d = res_vld_q;
    res_dat_d = res_dat_q;
    res_id_d  = res_id_q;
    ptr_d     = ptr_q;
    if (hs) begin
      op_vld_d = 1'b1;
      op_dat_d = gnt_dat;
      op_id_d  = gnt_idx;
      ptr_d    = ptr_nxt;
    end else if (s2_load) begin
      op_vld_d = 1'b0;
    end
    if (s2_load) begin
      res_vld_d = 1'b1;
      res_dat_d = red_dout;
      res_id_d  = op_id_q;
    end else if (res_vld_q && res_ready) begin
      res_vld_d = 1'b0;
      res_dat_d = '0;
      res_id_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_vld_q  <= 1'b0;
      op_dat_q  <= '0;
      op_id_q   <= '0;
      res_vld_q <= 1'b0;
      res_dat_q <= '0;
      res_id_q  <= '0;
      ptr_q     <= '0;
    end else begin
      op_vld_q  <= op_vld_d;
      op_dat_q  <= op_dat_d;
      op_id_q   <= op_id_d;
      res_vld_q <= res_vld_d;
      res_dat_q <= res_dat_d;
      res_id_q  <= res_id_d;
      ptr_q     <= ptr_d;
    end
  end

`ifdef BARRET_SCHED_RANGE_CHECK_EN
  localparam logic [DOUT_W:0] MOD_L = (DOUT_W+1)'(MODULUS);
  logic err_q, err_d;

  // Flags a reducer output that is not a canonical residue; data still passes through.
  assign err_d = err_q | (s2_load && ({1'b0, red_dout} >= MOD_L));

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`else
  localparam logic [31:0] MOD_L = MODULUS;
  logic unused_mod;
  assign unused_mod = ^MOD_L;
  assign err = 1'b0;
`endif

  assign red_din   = op_dat_q;
  assign res_valid = res_vld_q;
  assign res_data  = res_dat_q;
  assign res_id    = res_id_q;
  assign busy      = op_vld_q | res_vld_q;

endmodule
